// File: rtl/axi_lite_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_ctrl
// Brief    : Single-outstanding AXI4-Lite master bridging a cmd/rsp port.
// Revision : 1.0
// ============================================================================
module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [1:0]              rsp_resp,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_ADDR      = 3'd1,
        RD_DATA      = 3'd2,
        WR_ADDR_DATA = 3'd3,
        WR_RESP      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic                    rsp_write_q, rsp_write_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    aw_done_q,   aw_done_d;
    logic                    w_done_q,    w_done_d;

    logic w_cmd_fire;
    logic w_aw_fire;
    logic w_w_fire;

    assign cmd_ready  = (state_q == IDLE) && !areset;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_aw_fire  = awvalid_q && awready;
    assign w_w_fire   = wvalid_q && wready;

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        case (state_q)
            IDLE: begin
                if (w_cmd_fire) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    rsp_write_d = 1'b0;
                    state_d     = RSP;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both have retired.
                if (w_aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    rsp_write_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = (state_q == RD_DATA);
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = '1;
    assign wvalid    = wvalid_q;
    assign bready    = (state_q == WR_RESP);
    assign rsp_valid = (state_q == RSP);
    assign rsp_write = rsp_write_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master_ctrl
// Brief    : Randomized bench with a memory-backed slave and transaction model.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_master_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          aclk;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb;

    axi_lite_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-command stimulus knobs (driver side) and their latched copies.
    logic [1:0] drv_inj;
    int drv_ar_dly, drv_aw_dly, drv_w_dly, drv_r_dly, drv_b_dly, drv_rsp_dly;
    logic [1:0] cur_inj;
    int cur_ar_dly, cur_aw_dly, cur_w_dly, cur_r_dly, cur_b_dly, cur_rsp_dly;

    // Transaction-level model state.
    typedef struct packed {
        logic          w;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] mmem [4096];
    logic [DW-1:0] smem [4096];
    bit            in_flight, ar_seen, r_seen, aw_seen, w_seen, b_seen, post_rst;
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;

    // Handshake observations handed from the monitor to the slave.
    bit            s_rst, s_ar, s_r, s_aw, s_w, s_b;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic [DW-1:0] s_wdata;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mmem[i] = '0;
            smem[i] = '0;
        end
    end

    // Slave + response consumer, driven just after each rising edge.
    initial begin
        bit            r_pend, b_pend, aw_got, w_got;
        int            r_cnt, b_cnt, ar_cnt, aw_cnt, w_cnt, rsp_cnt;
        logic [AW-1:0] r_addr, aw_addr;
        logic [DW-1:0] w_dat;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        r_cnt = 0; b_cnt = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rsp_cnt = 0;
        r_addr = '0; aw_addr = '0; w_dat = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; awready = 0;
        wready = 0; bvalid = 0; bresp = '0; rsp_ready = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (s_rst) begin
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rsp_cnt = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rsp_ready = 0;
            end else begin
                if (s_r) rvalid = 0;
                if (s_b) bvalid = 0;
                if (s_ar) begin r_pend = 1; r_addr = s_araddr; r_cnt = 0; end
                if (s_aw) begin aw_got = 1; aw_addr = s_awaddr; end
                if (s_w)  begin w_got = 1; w_dat = s_wdata; end
                if (aw_got && w_got) begin
                    smem[aw_addr] = w_dat;
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (r_pend) begin
                    if (r_cnt >= cur_r_dly) begin
                        rvalid = 1; rdata = smem[r_addr]; rresp = cur_inj; r_pend = 0;
                    end else r_cnt++;
                end
                if (b_pend) begin
                    if (b_cnt >= cur_b_dly) begin
                        bvalid = 1; bresp = cur_inj; b_pend = 0;
                    end else b_cnt++;
                end
                arready   = arvalid && (ar_cnt >= cur_ar_dly);
                ar_cnt    = arvalid ? ar_cnt + 1 : 0;
                awready   = awvalid && (aw_cnt >= cur_aw_dly);
                aw_cnt    = awvalid ? aw_cnt + 1 : 0;
                wready    = wvalid && (w_cnt >= cur_w_dly);
                w_cnt     = wvalid ? w_cnt + 1 : 0;
                rsp_ready = rsp_valid && (rsp_cnt >= cur_rsp_dly);
                rsp_cnt   = rsp_valid ? rsp_cnt + 1 : 0;
            end
        end
    end

    // Compare process: checks every output on every falling edge.
    initial begin
        rsp_t e;
        in_flight = 0; ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
        post_rst = 0; cur_write = 0; cur_addr = '0; cur_data = '0; cur_inj = '0;
        cur_ar_dly = 0; cur_aw_dly = 0; cur_w_dly = 0; cur_r_dly = 0; cur_b_dly = 0; cur_rsp_dly = 0;
        forever begin
            @(negedge aclk);
            s_rst = areset;
            s_ar = arvalid && arready; s_r = rvalid && rready;
            s_aw = awvalid && awready; s_w = wvalid && wready; s_b = bvalid && bready;
            s_araddr = araddr; s_awaddr = awaddr; s_wdata = wdata;
            if (areset) begin
                chk("cmd_ready_in_reset", cmd_ready, 0);
                in_flight = 0; exp_q.delete();
                ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
                post_rst = 1;
            end else begin
                if (post_rst) begin
                    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 0);
                    chk("rst_araddr", araddr, 0);
                    chk("rst_awaddr", awaddr, 0);
                    chk("rst_wdata", wdata, 0);
                    chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, 0);
                    post_rst = 0;
                end
                chk("cmd_ready", cmd_ready, !in_flight);
                chk("arvalid", arvalid, in_flight && !cur_write && !ar_seen);
                chk("rready", rready, in_flight && !cur_write && ar_seen && !r_seen);
                chk("awvalid", awvalid, in_flight && cur_write && !aw_seen);
                chk("wvalid", wvalid, in_flight && cur_write && !w_seen);
                chk("bready", bready, in_flight && cur_write && aw_seen && w_seen && !b_seen);
                chk("rsp_valid", rsp_valid, in_flight && (r_seen || b_seen));
                chk("wstrb", wstrb, 4'hF);
                if (arvalid) chk("araddr", araddr, cur_addr);
                if (awvalid) chk("awaddr", awaddr, cur_addr);
                if (wvalid)  chk("wdata", wdata, cur_data);
                if (rsp_valid && exp_q.size() > 0) begin
                    chk("rsp_write", rsp_write, exp_q[0].w);
                    chk("rsp_resp", rsp_resp, exp_q[0].resp);
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                end
                if (s_ar) ar_seen = 1;
                if (s_r)  r_seen = 1;
                if (s_aw) aw_seen = 1;
                if (s_w)  w_seen = 1;
                if (s_b)  b_seen = 1;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    in_flight = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    cur_write = cmd_write; cur_addr = cmd_addr; cur_data = cmd_wdata;
                    cur_inj = drv_inj;
                    cur_ar_dly = drv_ar_dly; cur_aw_dly = drv_aw_dly; cur_w_dly = drv_w_dly;
                    cur_r_dly = drv_r_dly; cur_b_dly = drv_b_dly; cur_rsp_dly = drv_rsp_dly;
                    in_flight = 1;
                    ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
                    e.w = cmd_write;
                    e.resp = drv_inj;
                    if (cmd_write) begin
                        mmem[cmd_addr] = cmd_wdata;
                        e.rdata = '0;
                    end else begin
                        e.rdata = mmem[cmd_addr];
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Driver tasks: entered and left just after a rising edge.
    task automatic present(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge aclk);
        while (!cmd_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
        @(posedge aclk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        present(w, a, d);
        wait_accept();
    endtask

    task automatic get_rsp(output logic w, output logic [1:0] r, output logic [DW-1:0] d);
        int n = 0;
        @(negedge aclk);
        while (!(rsp_valid && rsp_ready) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!(rsp_valid && rsp_ready)) chk("rsp_timeout", 0, 1);
        w = rsp_write; r = rsp_resp; d = rsp_rdata;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          gw;
        logic [1:0]    gr;
        logic [DW-1:0] gd;
        logic [AW-1:0] ra;
        int            n;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        drv_inj = 0; drv_ar_dly = 0; drv_aw_dly = 0; drv_w_dly = 0;
        drv_r_dly = 0; drv_b_dly = 0; drv_rsp_dly = 0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 0;
        @(negedge aclk);
        chk("tp_rst_cmd_ready", cmd_ready, 1);
        chk("tp_rst_rsp_valid", rsp_valid, 0);
        chk("tp_rst_axi_valids", {arvalid, awvalid, wvalid}, 0);
        @(posedge aclk);
        #1;

        // Write then read back.
        send(1, 12'h010, 32'hDEADBEEF);
        #1;
        chk("tp_wr_awaddr", awaddr, 12'h010);
        chk("tp_wr_wdata", wdata, 32'hDEADBEEF);
        chk("tp_wr_wstrb", wstrb, 4'hF);
        get_rsp(gw, gr, gd);
        chk("tp_wr_rsp", {gw, gr, gd}, {1'b1, 2'd0, 32'h0});
        send(0, 12'h010, '0);
        #1;
        chk("tp_rd_araddr", araddr, 12'h010);
        get_rsp(gw, gr, gd);
        chk("tp_rd_rsp", {gw, gr, gd}, {1'b0, 2'd0, 32'hDEADBEEF});

        // W accepted three cycles ahead of AW.
        drv_aw_dly = 3; drv_w_dly = 0;
        send(1, 12'h030, 32'hCAFEF00D);
        @(negedge aclk);
        chk("tp_stag_c1", {awvalid, wvalid}, 2'b11);
        @(negedge aclk);
        chk("tp_stag_c2", {awvalid, wvalid}, 2'b10);
        @(negedge aclk);
        chk("tp_stag_c3", {awvalid, wvalid}, 2'b10);
        @(posedge aclk);
        #1;
        get_rsp(gw, gr, gd);
        chk("tp_stag_rsp", {gw, gr, gd}, {1'b1, 2'd0, 32'h0});
        drv_aw_dly = 0;

        // Response held off with a second command waiting.
        drv_rsp_dly = 5;
        send(0, 12'h010, '0);
        present(1, 12'h020, 32'h12345678);
        n = 0;
        @(negedge aclk);
        while (!rsp_valid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("tp_hold_cmd_ready", cmd_ready, 0);
            chk("tp_hold_no_addr", {arvalid, awvalid}, 0);
            chk("tp_hold_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEADBEEF});
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        wait_accept();
        get_rsp(gw, gr, gd);
        chk("tp_hold_second_rsp", {gw, gr, gd}, {1'b1, 2'd0, 32'h0});
        drv_rsp_dly = 0;

        // SLVERR passthrough on a read.
        drv_inj = 2;
        send(0, 12'h020, '0);
        get_rsp(gw, gr, gd);
        chk("tp_slverr_rsp", {gw, gr, gd}, {1'b0, 2'd2, 32'h12345678});
        drv_inj = 0;

        // Reset while waiting on B.
        drv_b_dly = 30;
        send(1, 12'h040, 32'hA5A55A5A);
        n = 0;
        @(negedge aclk);
        while (!bready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("tp_rst_reached_wr_resp", bready, 1);
        @(posedge aclk);
        #1;
        areset = 1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 0;
        @(negedge aclk);
        chk("tp_abort_state", {bready, rsp_valid, cmd_ready}, 3'b001);
        @(posedge aclk);
        #1;
        drv_b_dly = 0;

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            drv_ar_dly = $urandom_range(0, 3);
            drv_aw_dly = $urandom_range(0, 3);
            drv_w_dly = $urandom_range(0, 3);
            drv_r_dly = $urandom_range(0, 3);
            drv_b_dly = $urandom_range(0, 3);
            drv_rsp_dly = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: drv_inj = 2'd2;
                1: drv_inj = 2'd3;
                default: drv_inj = 2'd0;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
            send(1'($urandom_range(0, 1)), ra, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end

        n = 0;
        @(negedge aclk);
        while (in_flight && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_idle", in_flight, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_ctrl.md
Name: axi_lite_master_ctrl

Overview:
- Single-outstanding AXI4-Lite master bridge, sitting directly upstream of the AXI4-Lite slave.
- Accepts simple read/write commands on a valid/ready command port and drives the AR/R/AW/W/B channels.
- Returns the data and response of each completed transaction on a valid/ready response port.
- Used by test/CPU-side logic that must not handle AXI channel ordering itself.

Parameters:
- ADDR_WIDTH, 12, byte/word address width; matches the slave buffer index width.
- DATA_WIDTH, 32, data width of the command, response and W/R channels.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_resp  out  2  RRESP or BRESP of the transaction.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- araddr  out  ADDR_WIDTH  AR address.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  DATA_WIDTH  R data.
- rresp  in  2  R response.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- awaddr  out  ADDR_WIDTH  AW address.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wdata  out  DATA_WIDTH  W data.
- wstrb  out  DATA_WIDTH/8  W strobes; constant all-ones.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- bresp  in  2  B response.
- bvalid  in  1  B valid.
- bready  out  1  B ready.

Behaviour:
- Reset (areset=1 at a clock edge):
  - State goes to IDLE.
  - arvalid, awvalid, wvalid, rready, bready and rsp_valid are 0.
  - araddr, awaddr, wdata, rsp_rdata, rsp_resp and rsp_write are 0.
  - cmd_ready is 0 while areset is high.
- Reset mid-transaction aborts immediately with no response; bench must also reset the slave.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RSP.
- IDLE:
  - cmd_ready = 1 (combinational: state==IDLE && !areset).
  - On cmd_valid&&cmd_ready, capture cmd_addr/cmd_wdata/cmd_write.
  - Read → RD_ADDR with arvalid=1 on the next cycle; write → WR_ADDR_DATA with awvalid=1 and wvalid=1 on the next cycle.
- RD_ADDR:
  - Hold arvalid and araddr stable until arready.
  - On arvalid&&arready, drop arvalid and go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&&rready, capture rdata/rresp into rsp_rdata/rsp_resp, set rsp_write=0, go to RSP.
- WR_ADDR_DATA:
  - AW and W complete independently.
  - Track aw_done and w_done flags; each valid drops the cycle after its own handshake.
  - Handshakes may occur in the same cycle or in either order.
  - When both are done (including same-cycle completion), go to WR_RESP.
  - wvalid must never be withdrawn before wready, even if AW completes first.
- WR_RESP:
  - bready=1.
  - On bvalid&&bready, capture bresp, set rsp_rdata=0 and rsp_write=1, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; cmd_ready is high the following cycle.
  - No bypass: one command per complete round trip.
- Channel-level rules:
  - All AXI valid outputs are registered.
  - No valid depends combinationally on any AXI ready.
  - rready and bready are asserted only in their own states.
  - cmd_valid is ignored outside IDLE.
  - Addresses wrap naturally; no range checking.
  - Non-OKAY responses (SLVERR=2, DECERR=3) are passed through unchanged.
- Minimum latency, read: cmd handshake at cycle 0 → arvalid at cycle 1 → AR handshake at ≥1 → rready at the next cycle → rsp_valid one cycle after the R handshake.

Test Plan:
- Reset held 3 cycles, then released → all AXI valids 0, rsp_valid 0, cmd_ready=1 on the first cycle after release.
- Write cmd addr=0x010, data=0xDEADBEEF against the slave → awaddr=0x010, wdata=0xDEADBEEF, wstrb=0xF; rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read cmd addr=0x010 after that write → araddr=0x010; rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0.
- Stub slave asserts wready 3 cycles before awready → wvalid drops after its handshake, awvalid holds until awready, exactly one B accepted, one response.
- rsp_ready held low for 5 cycles with a second cmd_valid pending → rsp_* stable, cmd_ready=0, no AR/AW issued until the response handshake.
- Stub returns rresp=2 on a read, then areset asserted while in WR_RESP on a following write → SLVERR (2) forwarded on rsp_resp; after reset, state IDLE, bready=0, no rsp_valid.
